muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide unit for the execute stage.
// A request accepted in IDLE runs for WIDTH iterations, then the unit spends
// one DONE cycle presenting the registered result. Latency is fixed at
// WIDTH+1 cycles from the accepting edge, for every op and operand value.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   start   request, sampled only in IDLE
//   op      00 MUL (low half), 01 MULHU (high half), 10 DIVU, 11 REMU
//   a, b    operands (multiplicand/dividend, multiplier/divisor)
//   busy    high in RUN and DONE; the core stalls on it
//   done    one-cycle pulse, result valid in that cycle
//   result  registered result, held until the next completion
//   zero    registered (result == 0)
module muldiv_unit #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] a_r, b_r;
   // hi/lo form one shared shift register. Multiply: hi is the upper product
   // half (hi[WIDTH] is the add carry), lo starts as the multiplier and fills
   // with product low bits. Divide: hi is the partial remainder, lo starts as
   // the dividend and fills with quotient bits from the right.
   logic [WIDTH:0]   hi, hi_n;
   logic [WIDTH-1:0] lo, lo_n;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift, div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] res_n;
   logic             last_iter;

   assign last_iter = (state == S_RUN) && (cnt == CNT_W'(1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (start) state_n = S_RUN;
         S_RUN:   if (last_iter) state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   // ---------------- one iteration of the datapath ----------------
   always_comb begin
      // Multiply step: conditional add into the upper half, then shift the
      // {carry, product} pair right by one.
      mul_sum   = hi + (lo[0] ? {1'b0, a_r} : '0);
      // Divide step: shift in the next dividend bit, trial-subtract divisor.
      div_shift = {hi[WIDTH-1:0], lo[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_r});
      div_diff  = div_shift - {1'b0, b_r};
      if (!op_r[1]) begin
         hi_n = {1'b0, mul_sum[WIDTH:1]};
         lo_n = {mul_sum[0], lo[WIDTH-1:1]};
      end else begin
         // b==0 always takes the subtract branch: quotient becomes all ones
         // and the remainder ends up holding the dividend, as required.
         hi_n = div_ge ? div_diff : div_shift;
         lo_n = {lo[WIDTH-2:0], div_ge};
      end
      // op[0] picks the high half (MULHU / remainder) over the low half.
      res_n = op_r[0] ? hi_n[WIDTH-1:0] : lo_n;
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         op_r   <= '0;
         a_r    <= '0;
         b_r    <= '0;
         hi     <= '0;
         lo     <= '0;
         result <= '0;
         zero   <= 1'b1;
      end else begin
         if (state == S_IDLE && start) begin
            cnt  <= CNT_W'(WIDTH);
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
            hi   <= '0;
            lo   <= op[1] ? a : b;
         end else if (state == S_RUN) begin
            cnt <= cnt - CNT_W'(1);
            hi  <= hi_n;
            lo  <= lo_n;
         end
         // The final iteration writes straight into the result register so
         // it is valid on entry to DONE.
         if (last_iter) begin
            result <= res_n;
            zero   <= (res_n == '0);
         end
      end
   end

endmodule
